// File: rtl/adc_coef_axis_rx_if.sv
// One AXI4-Stream coefficient lane (32-bit word, valid/ready handshake).
interface adc_coef_axis_rx_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/adc_coef_axis_rx.sv
// Coefficient set receiver: four AXIS words are captured into shadow slots and
// committed to the active set together on a frame boundary.
module adc_coef_axis_rx #(
  parameter logic [31:0] DEF_GAIN    = 32'h35A0_0000,
  parameter logic [31:0] DEF_OFFSET  = 32'hC120_0000,
  parameter logic [31:0] DEF_FACTOR  = 32'h3F80_0000,
  parameter logic [31:0] DEF_FOFS    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 1024
) (
  input  logic                i_clk,
  input  logic                i_rst,
  adc_coef_axis_rx_if.slave   s_gain_axis,
  adc_coef_axis_rx_if.slave   s_ofs_axis,
  adc_coef_axis_rx_if.slave   s_fac_axis,
  adc_coef_axis_rx_if.slave   s_fofs_axis,
  input  logic                i_frame_sync,
  input  logic                i_freeze,
  input  logic                i_err_clr,
  output logic [31:0]         o_gain,
  output logic [31:0]         o_offset,
  output logic [31:0]         o_factor,
  output logic [31:0]         o_fofs,
  output logic                o_coef_valid,
  output logic                o_coef_update,
  output logic                o_coef_changed,
  output logic                o_coef_err,
  output logic [15:0]         o_commit_cnt
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  logic [31:0]   word   [4];
  logic [31:0]   shadow [4];
  logic [31:0]   active [4];
  logic [3:0]    vld;
  logic [3:0]    rdy;
  logic [3:0]    hs;
  logic [3:0]    pending;
  logic [TW-1:0] tmo_cnt;
  logic          partial;
  logic          commit;
  logic          timeout;
  logic          differs;

  assign word[0] = s_gain_axis.tdata;
  assign word[1] = s_ofs_axis.tdata;
  assign word[2] = s_fac_axis.tdata;
  assign word[3] = s_fofs_axis.tdata;
  assign vld     = {s_fofs_axis.tvalid, s_fac_axis.tvalid, s_ofs_axis.tvalid, s_gain_axis.tvalid};

  assign rdy = {4{~i_rst & ~i_freeze}} & ~pending;
  assign s_gain_axis.tready = rdy[0];
  assign s_ofs_axis.tready  = rdy[1];
  assign s_fac_axis.tready  = rdy[2];
  assign s_fofs_axis.tready = rdy[3];
  assign hs = vld & rdy;

  assign partial = (|pending) & ~(&pending);
  assign commit  = i_frame_sync & ~i_freeze & (&pending);
  // A set that sits partial for TIMEOUT_CYC edges is dropped, even if it would complete now.
  assign timeout = ~i_freeze & partial & (tmo_cnt == TMO_LAST);
  assign differs = (shadow[0] != active[0]) | (shadow[1] != active[1]) |
                   (shadow[2] != active[2]) | (shadow[3] != active[3]);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      active[0]      <= DEF_GAIN;
      active[1]      <= DEF_OFFSET;
      active[2]      <= DEF_FACTOR;
      active[3]      <= DEF_FOFS;
      for (int k = 0; k < 4; k++) shadow[k] <= '0;
      pending        <= '0;
      tmo_cnt        <= '0;
      o_coef_valid   <= 1'b0;
      o_coef_update  <= 1'b0;
      o_coef_changed <= 1'b0;
      o_coef_err     <= 1'b0;
      o_commit_cnt   <= '0;
    end else begin
      o_coef_update  <= commit;
      o_coef_changed <= commit & differs;
      if (commit) begin
        for (int k = 0; k < 4; k++) active[k] <= shadow[k];
        o_coef_valid <= 1'b1;
        o_commit_cnt <= o_commit_cnt + 16'd1;
      end
      for (int k = 0; k < 4; k++) begin
        if (hs[k]) shadow[k] <= word[k];
      end
      if (timeout || commit) pending <= '0;
      else                   pending <= pending | hs;
      tmo_cnt <= (~i_freeze & partial & ~timeout) ? tmo_cnt + 1'b1 : '0;
      if (timeout)        o_coef_err <= 1'b1;
      else if (i_err_clr) o_coef_err <= 1'b0;
    end
  end

  assign o_gain   = active[0];
  assign o_offset = active[1];
  assign o_factor = active[2];
  assign o_fofs   = active[3];

endmodule

// File: tb/tb_adc_coef_axis_rx.sv
// Bench for adc_coef_axis_rx: directed vectors, per-cycle compare against a
// transaction-level model of the coefficient set, plus literal spot checks.
module tb_adc_coef_axis_rx;
  localparam int T = 1024;
  localparam logic [31:0] DEF [4] = '{32'h35A0_0000, 32'hC120_0000, 32'h3F80_0000, 32'h0000_0000};

  logic        clk = 1'b0;
  logic        rst, fs, frz, eclr;
  logic [31:0] d_data [4];
  logic [3:0]  d_vld;
  logic [31:0] o_gain, o_offset, o_factor, o_fofs;
  logic        o_coef_valid, o_coef_update, o_coef_changed, o_coef_err;
  logic [15:0] o_commit_cnt;
  int          n_chk = 0;
  int          n_fail = 0;

  adc_coef_axis_rx_if gain_if ();
  adc_coef_axis_rx_if ofs_if ();
  adc_coef_axis_rx_if fac_if ();
  adc_coef_axis_rx_if fofs_if ();

  assign gain_if.tdata  = d_data[0];
  assign ofs_if.tdata   = d_data[1];
  assign fac_if.tdata   = d_data[2];
  assign fofs_if.tdata  = d_data[3];
  assign gain_if.tvalid = d_vld[0];
  assign ofs_if.tvalid  = d_vld[1];
  assign fac_if.tvalid  = d_vld[2];
  assign fofs_if.tvalid = d_vld[3];

  wire [3:0] dut_rdy = {fofs_if.tready, fac_if.tready, ofs_if.tready, gain_if.tready};

  adc_coef_axis_rx #(.TIMEOUT_CYC(T)) dut (
    .i_clk(clk), .i_rst(rst),
    .s_gain_axis(gain_if), .s_ofs_axis(ofs_if), .s_fac_axis(fac_if), .s_fofs_axis(fofs_if),
    .i_frame_sync(fs), .i_freeze(frz), .i_err_clr(eclr),
    .o_gain(o_gain), .o_offset(o_offset), .o_factor(o_factor), .o_fofs(o_fofs),
    .o_coef_valid(o_coef_valid), .o_coef_update(o_coef_update),
    .o_coef_changed(o_coef_changed), .o_coef_err(o_coef_err), .o_commit_cnt(o_commit_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the set of words held, which slots hold one, and how long a partial set has waited.
  logic [31:0] m_act [4];
  logic [31:0] m_shd [4];
  bit   [3:0]  m_have;
  bit          m_valid, m_upd, m_chg, m_err, m_live;
  logic [15:0] m_cnt;
  int          m_wait;

  always @(posedge clk) begin
    bit took [4];
    bit is_partial, fire, do_commit, diff;
    if (rst) begin
      m_act = DEF;
      m_have = '0; m_valid = 0; m_upd = 0; m_chg = 0; m_err = 0;
      m_cnt = 0; m_wait = 0; m_live = 1;
    end else if (m_live) begin
      is_partial = (m_have != 4'h0) && (m_have != 4'hF);
      fire       = !frz && is_partial && (m_wait == T - 1);
      do_commit  = fs && !frz && (m_have == 4'hF);
      diff = 0;
      for (int k = 0; k < 4; k++) begin
        took[k] = d_vld[k] && !frz && !m_have[k];
        if (m_shd[k] != m_act[k]) diff = 1;
      end
      m_upd = do_commit;
      m_chg = do_commit && diff;
      if (do_commit) begin
        m_act = m_shd; m_cnt = m_cnt + 1; m_valid = 1; m_have = '0;
      end
      for (int k = 0; k < 4; k++) if (took[k]) begin
        m_shd[k] = d_data[k]; m_have[k] = 1;
      end
      if (fire) begin m_have = '0; m_err = 1; end
      else if (eclr) m_err = 0;
      m_wait = (!frz && is_partial && !fire) ? m_wait + 1 : 0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("m_gain", o_gain, m_act[0]);
      chk("m_offset", o_offset, m_act[1]);
      chk("m_factor", o_factor, m_act[2]);
      chk("m_fofs", o_fofs, m_act[3]);
      chk("m_valid", {31'd0, o_coef_valid}, {31'd0, m_valid});
      chk("m_update", {31'd0, o_coef_update}, {31'd0, m_upd});
      chk("m_changed", {31'd0, o_coef_changed}, {31'd0, m_chg});
      chk("m_err", {31'd0, o_coef_err}, {31'd0, m_err});
      chk("m_cnt", {16'd0, o_commit_cnt}, {16'd0, m_cnt});
      chk("m_tready", {28'd0, dut_rdy}, {28'd0, (rst || frz) ? 4'h0 : ~m_have});
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic look();
    @(negedge clk); #1;
  endtask

  initial begin
    rst = 1; fs = 0; frz = 0; eclr = 0; d_vld = '0;
    for (int k = 0; k < 4; k++) d_data[k] = '0;
    step(); step();
    rst = 0;
    look();
    chk("t1_gain", o_gain, 32'h35A0_0000);
    chk("t1_offset", o_offset, 32'hC120_0000);
    chk("t1_valid", {31'd0, o_coef_valid}, 32'd0);
    chk("t1_tready", {28'd0, dut_rdy}, 32'hF);

    // T2: full set captured, then committed
    d_data = '{32'h35A0_0000, 32'hC120_0000, 32'h4230_0000, 32'h0};
    d_vld = 4'hF;
    step();
    look();
    chk("t2_tready_drop", {28'd0, dut_rdy}, 32'h0);
    fs = 1; step(); fs = 0;
    look();
    chk("t2_update", {31'd0, o_coef_update}, 32'd1);
    chk("t2_changed", {31'd0, o_coef_changed}, 32'd1);
    chk("t2_valid", {31'd0, o_coef_valid}, 32'd1);
    chk("t2_cnt", {16'd0, o_commit_cnt}, 32'd1);
    chk("t2_factor", o_factor, 32'h4230_0000);
    chk("t2_tready_rise", {28'd0, dut_rdy}, 32'hF);

    // T3: frame_sync on the capture cycle does not commit; the next one does, unchanged data
    fs = 1; step();
    look();
    chk("t3_no_early", {31'd0, o_coef_update}, 32'd0);
    step(); fs = 0; d_vld = '0;
    look();
    chk("t3_update", {31'd0, o_coef_update}, 32'd1);
    chk("t3_changed", {31'd0, o_coef_changed}, 32'd0);
    chk("t3_cnt", {16'd0, o_commit_cnt}, 32'd2);
    chk("t3_gain", o_gain, 32'h35A0_0000);

    // T4: partial set times out exactly T edges after its first word
    d_vld = 4'b0011; step(); d_vld = '0;
    fs = 1; step(); fs = 0;
    look();
    chk("t4_partial_no_commit", {31'd0, o_coef_update}, 32'd0);
    repeat (T - 2) step();
    look();
    chk("t4_err_not_yet", {31'd0, o_coef_err}, 32'd0);
    step();
    look();
    chk("t4_err", {31'd0, o_coef_err}, 32'd1);
    chk("t4_tready", {28'd0, dut_rdy}, 32'hF);
    eclr = 1; step(); eclr = 0;
    look();
    chk("t4_err_clr", {31'd0, o_coef_err}, 32'd0);

    // Timeout beats a completing handshake and a simultaneous error clear
    d_data = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444};
    d_vld = 4'b0111; step(); d_vld = '0;
    repeat (T - 1) step();
    d_vld = 4'b1000; eclr = 1; step(); d_vld = '0; eclr = 0;
    look();
    chk("t4_tmo_err_wins", {31'd0, o_coef_err}, 32'd1);
    chk("t4_tmo_dropped", {28'd0, dut_rdy}, 32'hF);
    fs = 1; step(); fs = 0;
    look();
    chk("t4_no_commit", {31'd0, o_coef_update}, 32'd0);
    chk("t4_cnt", {16'd0, o_commit_cnt}, 32'd2);
    eclr = 1; step(); eclr = 0;

    // T5: last handshake coincides with frame_sync
    d_data = '{32'h3F00_0000, 32'h40A0_0000, 32'h3F80_0000, 32'h3DCC_CCCD};
    d_vld = 4'b0111; step();
    d_vld = 4'b1000; fs = 1; step(); d_vld = '0; fs = 0;
    look();
    chk("t5_no_commit", {31'd0, o_coef_update}, 32'd0);
    fs = 1; step(); fs = 0;
    look();
    chk("t5_update", {31'd0, o_coef_update}, 32'd1);
    chk("t5_changed", {31'd0, o_coef_changed}, 32'd1);
    chk("t5_cnt", {16'd0, o_commit_cnt}, 32'd3);
    chk("t5_gain", o_gain, 32'h3F00_0000);
    chk("t5_fofs", o_fofs, 32'h3DCC_CCCD);

    // T6: freeze blocks commit; reset restores defaults and drops the shadow set
    d_data = '{32'd1, 32'd2, 32'd3, 32'd4};
    d_vld = 4'hF; step(); d_vld = '0;
    frz = 1; fs = 1; step(); fs = 0;
    look();
    chk("t6_frz_no_commit", {31'd0, o_coef_update}, 32'd0);
    chk("t6_frz_tready", {28'd0, dut_rdy}, 32'h0);
    chk("t6_frz_gain", o_gain, 32'h3F00_0000);
    repeat (5) step();
    frz = 0; rst = 1; step(); rst = 0;
    look();
    chk("t6_rst_gain", o_gain, 32'h35A0_0000);
    chk("t6_rst_factor", o_factor, 32'h3F80_0000);
    chk("t6_rst_cnt", {16'd0, o_commit_cnt}, 32'd0);
    chk("t6_rst_valid", {31'd0, o_coef_valid}, 32'd0);
    fs = 1; step(); fs = 0;
    look();
    chk("t6_shadow_dropped", {31'd0, o_coef_update}, 32'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
